// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: 7-bit even-parity UART receiver with 16x (configurable)
// oversampling. A free-running divider makes the sample tick, a 2-flop
// synchronizer cleans up rx, and a single FSM samples each bit at its centre.
module uart_rx_oversampled #(
  parameter int CLOCK_RATE = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       rx,
  output logic [6:0] data,
  output logic       new_data,
  output logic       correct_data,
  output logic       frame_error,
  output logic       busy
);

  localparam int DIV_RAW = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW      = $clog2(OVERSAMPLE);

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_s;
  logic [DW-1:0] div_cnt;
  logic          tick;
  logic          start_hit;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic [6:0]    shift_reg;
  logic          parity_bit;
  logic          armed;

  assign tick      = (div_cnt == DIV_LAST);
  assign start_hit = tick && (state == IDLE) && armed && !rx_s;

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Tick divider: wraps every DIV clocks, realigned to 0 on start detection.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      div_cnt <= '0;
    end else if (start_hit || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Receive FSM: half-bit start check, then full-bit steps to each bit centre.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      parity_bit   <= 1'b0;
      armed        <= 1'b0;
      data         <= '0;
      new_data     <= 1'b0;
      correct_data <= 1'b0;
      frame_error  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      new_data <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            if (armed && !rx_s) begin
              state    <= START;
              tick_cnt <= '0;
              busy     <= 1'b1;
            end else if (rx_s) begin
              armed <= 1'b1;
            end
          end
          START: begin
            if (tick_cnt == HALF_LAST) begin
              tick_cnt <= '0;
              if (!rx_s) begin
                state   <= DATA;
                bit_cnt <= '0;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          DATA: begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt  <= '0;
              shift_reg <= {rx_s, shift_reg[6:1]};
              if (bit_cnt == 3'd6) begin
                state <= PARITY;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          PARITY: begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt   <= '0;
              parity_bit <= rx_s;
              state      <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          STOP: begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt     <= '0;
              data         <= shift_reg;
              correct_data <= ~(^shift_reg ^ parity_bit) & rx_s;
              frame_error  <= ~rx_s;
              new_data     <= 1'b1;
              busy         <= 1'b0;
              state        <= IDLE;
              if (!rx_s) begin
                armed <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Testbench for uart_rx_oversampled: directed and random frames, expected
// characters queued by the stimulus and checked by an independent monitor.
module tb_uart_rx_oversampled;

  localparam int BIT_CLKS = 64;

  typedef struct {
    logic [6:0] data;
    logic       correct;
    logic       ferr;
    int         edgeCycle;
  } exp_t;

  logic       clk;
  logic       rstN;
  logic       rx;
  logic [6:0] data;
  logic       new_data;
  logic       correct_data;
  logic       frame_error;
  logic       busy;

  exp_t expQ[$];
  int   compared;
  int   mismatched;
  int   cycle;
  int   strobes;
  int   busyRises;
  logic busyPrev;
  logic ndPrev;
  logic [6:0] lastData;
  logic lastCorrect;
  logic lastFerr;

  uart_rx_oversampled #(
    .CLOCK_RATE(6400),
    .BAUD_RATE (100),
    .OVERSAMPLE(16)
  ) dut (
    .clk         (clk),
    .rstN        (rstN),
    .rx          (rx),
    .data        (data),
    .new_data    (new_data),
    .correct_data(correct_data),
    .frame_error (frame_error),
    .busy        (busy)
  );

  // Free-running system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Monitor: samples on the falling edge, pops one expectation per strobe.
  task automatic monitorLoop();
    exp_t e;
    int   lat;
    forever begin
      @(negedge clk);
      cycle++;
      if (busy && !busyPrev) busyRises++;
      busyPrev = busy;
      if (new_data && ndPrev) checkOutput("strobeWidth", 2, 1);
      ndPrev = new_data;
      if (new_data) begin
        strobes++;
        if (expQ.size() == 0) begin
          checkOutput("unexpectedStrobe", 1, 0);
        end else begin
          e   = expQ.pop_front();
          lat = cycle - e.edgeCycle;
          checkOutput("data", int'(data), int'(e.data));
          checkOutput("correct_data", int'(correct_data), int'(e.correct));
          checkOutput("frame_error", int'(frame_error), int'(e.ferr));
          checkOutput("strobeLatencyInWindow", int'(lat >= 606 && lat <= 618), 1);
          lastData    = e.data;
          lastCorrect = e.correct;
          lastFerr    = e.ferr;
        end
      end
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".data"}, int'(data), 0);
    checkOutput({tag, ".new_data"}, int'(new_data), 0);
    checkOutput({tag, ".correct_data"}, int'(correct_data), 0);
    checkOutput({tag, ".frame_error"}, int'(frame_error), 0);
    checkOutput({tag, ".busy"}, int'(busy), 0);
  endtask

  // Sends one frame; abortBit >= 0 pulses reset in the middle of that bit.
  task automatic sendFrame(input logic [6:0] d, input logic parFlip,
                           input logic stopBit, input int abortBit);
    logic [9:0] bits;
    logic       par;
    exp_t       e;
    par  = logic'($countones(d) % 2) ^ parFlip;
    bits = {stopBit, par, d, 1'b0};
    if (abortBit < 0) begin
      e.data      = d;
      e.correct   = ((($countones(d) + int'(par)) % 2) == 0) && stopBit;
      e.ferr      = !stopBit;
      e.edgeCycle = cycle;
      expQ.push_back(e);
    end
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      if (i == abortBit) begin
        repeat (BIT_CLKS / 2) @(negedge clk);
        rstN = 1'b0;
        @(negedge clk);
        checkAllZero("midFrameReset");
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        rx   = 1'b1;
        lastData    = '0;
        lastCorrect = 1'b0;
        lastFerr    = 1'b0;
        return;
      end
      repeat (BIT_CLKS) @(negedge clk);
    end
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 1000 && expQ.size() != 0; i++) @(negedge clk);
    checkOutput("queueDrained", expQ.size(), 0);
  endtask

  task automatic applyStimulus();
    int s0;
    int b0;
    logic [6:0] d;
    logic pf;
    logic sb;

    // Reset with idle line.
    rx   = 1'b1;
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rstN = 1'b1;
    repeat (200) @(negedge clk);
    checkOutput("idleStrobes", strobes, 0);
    checkOutput("idleBusy", int'(busy), 0);

    // Good frame and parity error.
    sendFrame(7'h55, 1'b0, 1'b1, -1);
    repeat (20) @(negedge clk);
    sendFrame(7'h41, 1'b1, 1'b1, -1);
    waitDrain();
    repeat (20) @(negedge clk);

    // Framing error followed by a held-low break.
    s0 = strobes;
    sendFrame(7'h7F, 1'b0, 1'b0, -1);
    repeat (1280) @(negedge clk);
    checkOutput("breakStrobes", strobes, s0 + 1);
    checkOutput("breakQueue", expQ.size(), 0);
    rx = 1'b1;
    repeat (128) @(negedge clk);
    sendFrame(7'h12, 1'b0, 1'b1, -1);
    waitDrain();
    repeat (20) @(negedge clk);

    // Short glitch on the line.
    s0 = strobes;
    b0 = busyRises;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    checkOutput("glitchBusyPulse", busyRises, b0 + 1);
    checkOutput("glitchBusyLow", int'(busy), 0);
    checkOutput("glitchStrobes", strobes, s0);
    checkOutput("glitchData", int'(data), int'(lastData));
    checkOutput("glitchCorrect", int'(correct_data), int'(lastCorrect));
    checkOutput("glitchFerr", int'(frame_error), int'(lastFerr));

    // Reset during data bit 3, then recovery.
    s0 = strobes;
    sendFrame(7'h6B, 1'b0, 1'b1, 4);
    repeat (128) @(negedge clk);
    checkOutput("abortStrobes", strobes, s0);
    checkAllZero("afterAbort");
    sendFrame(7'h2A, 1'b0, 1'b1, -1);
    waitDrain();

    // Random frames with random gaps, parity and stop errors.
    for (int n = 0; n < 20; n++) begin
      d  = 7'($urandom_range(0, 127));
      pf = ($urandom_range(0, 3) == 0);
      sb = ($urandom_range(0, 7) != 0);
      sendFrame(d, pf, sb, -1);
      if (!sb) begin
        rx = 1'b1;
        repeat (BIT_CLKS + $urandom_range(0, 50)) @(negedge clk);
      end else begin
        repeat ($urandom_range(0, 100)) @(negedge clk);
      end
    end
    waitDrain();
    repeat (50) @(negedge clk);
  endtask

  // Stimulus and monitor run side by side; the run ends with the stimulus.
  initial begin
    compared    = 0;
    mismatched  = 0;
    cycle       = 0;
    strobes     = 0;
    busyRises   = 0;
    busyPrev    = 1'b0;
    ndPrev      = 1'b0;
    lastData    = '0;
    lastCorrect = 1'b0;
    lastFerr    = 1'b0;
    rx          = 1'b1;
    rstN        = 1'b0;
    fork
      monitorLoop();
      applyStimulus();
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
